// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the datapath wrapper that hosts it.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package prog_loader_pkg;

  localparam int ROM_WORDS_DEF = 32;  // instruction-memory depth in 16-bit words
  localparam int ADDR_W_DEF    = 16;  // instruction-memory byte-address width
  localparam int CSUM_W        = 8;   // running XOR checksum width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_FINISH,
    ST_ERROR
  } state_e;

  // Status outputs that are a pure function of the state being entered.
  typedef struct packed {
    logic in_ready;
    logic busy;
    logic cpu_hold;
    logic done;
    logic err;
  } ctrl_t;

  // Decode for the state being entered, so every status output comes straight from a flop.
  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c.in_ready = (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
                 (s == ST_DATA_LO) || (s == ST_CHECK);
    c.busy     = (s != ST_IDLE);
    c.cpu_hold = (s != ST_IDLE);
    c.done     = (s == ST_FINISH);
    c.err      = (s == ST_ERROR);
    return c;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, big-endian 16-bit words into imem, XOR checksum trailer.
// Latency: imem write one cycle after the low-byte accept; done one cycle after the checksum accept.
// Backpressure: in_ready high only while a header/data/checksum byte is expected; one byte per cycle sustained.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ROM_WORDS = ROM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so a count equal to ROM_WORDS is representable.
  localparam int CNT_W = $clog2(ROM_WORDS) + 1;

  state_e              state_q;
  ctrl_t               ctrl_q;
  logic [7:0]          len_hi_q;
  logic [7:0]          hi_q;
  logic [CSUM_W-1:0]   csum_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [15:0]         imem_wdata_q;

  logic                accept;
  logic [15:0]         len_word;
  logic                len_oversize;
  logic [CNT_W-1:0]    cnt_d;
  logic                last_word;
  logic [CSUM_W-1:0]   csum_d;

  // A byte moves only when the source offers it and this block is asking for one.
  assign accept       = in_valid && ctrl_q.in_ready;
  assign len_word     = {len_hi_q, in_byte};
  assign len_oversize = (32'(len_word) > 32'(ROM_WORDS));
  assign cnt_d        = cnt_q + CNT_W'(1);
  assign last_word    = (cnt_d == len_q);
  assign csum_d       = csum_q ^ CSUM_W'(in_byte);

  // Loader FSM with registered status, write strobe, address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= ctrl_for(ST_IDLE);
      len_hi_q     <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      // The write strobe is a single-cycle pulse unless a low byte lands this cycle.
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LEN_HI;
            ctrl_q  <= ctrl_for(ST_LEN_HI);
            csum_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_q <= in_byte;
            state_q  <= ST_LEN_LO;
            ctrl_q   <= ctrl_for(ST_LEN_LO);
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            // Oversize lengths are rejected before any word is written.
            if (len_oversize) begin
              state_q <= ST_ERROR;
              ctrl_q  <= ctrl_for(ST_ERROR);
            end else if (len_word == 16'd0) begin
              len_q   <= '0;
              state_q <= ST_CHECK;
              ctrl_q  <= ctrl_for(ST_CHECK);
            end else begin
              len_q   <= CNT_W'(len_word);
              state_q <= ST_DATA_HI;
              ctrl_q  <= ctrl_for(ST_DATA_HI);
            end
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            hi_q    <= in_byte;
            csum_q  <= csum_d;
            state_q <= ST_DATA_LO;
            ctrl_q  <= ctrl_for(ST_DATA_LO);
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            csum_q       <= csum_d;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= ADDR_W'({cnt_q, 1'b0});
            imem_wdata_q <= {hi_q, in_byte};
            cnt_q        <= cnt_d;
            if (last_word) begin
              state_q <= ST_CHECK;
              ctrl_q  <= ctrl_for(ST_CHECK);
            end else begin
              state_q <= ST_DATA_HI;
              ctrl_q  <= ctrl_for(ST_DATA_HI);
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (CSUM_W'(in_byte) == csum_q) begin
              state_q <= ST_FINISH;
              ctrl_q  <= ctrl_for(ST_FINISH);
            end else begin
              state_q <= ST_ERROR;
              ctrl_q  <= ctrl_for(ST_ERROR);
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          ctrl_q  <= ctrl_for(ST_IDLE);
        end
        ST_ERROR: begin
          // A fresh start both clears the sticky error and begins a new session.
          if (start) begin
            state_q <= ST_LEN_HI;
            ctrl_q  <= ctrl_for(ST_LEN_HI);
            csum_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ctrl_q  <= ctrl_for(ST_IDLE);
        end
      endcase
    end
  end

  assign in_ready   = ctrl_q.in_ready;
  assign busy       = ctrl_q.busy;
  assign cpu_hold   = ctrl_q.cpu_hold;
  assign done       = ctrl_q.done;
  assign err        = ctrl_q.err;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader against a word-list/XOR model of the stream.
// Latency: checks write one cycle after low-byte accept and done one cycle after checksum accept.
// Backpressure: byte source waits on in_ready with a bounded cycle budget.
module tb_prog_loader;

  localparam int ROM_W = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int gap_pct = 0;
  int hold_drops = 0;
  logic [15:0] words [0:ROM_W-1];

  // Free-running counters of write pulses and done pulses.
  int we_total = 0;
  int done_total = 0;
  always @(negedge clk) begin
    if (imem_we) we_total <= we_total + 1;
    if (done)    done_total <= done_total + 1;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte, optionally after a random idle gap, and wait for it to be taken.
  task automatic send_byte(input logic [7:0] b);
    int  waited;
    bit  got;
    if (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      repeat (int'($urandom_range(1, 3))) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    got      = 1'b0;
    waited   = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      got = in_ready;
      if (!cpu_hold) hold_drops = hold_drops + 1;
      @(posedge clk); #1;
      waited = waited + 1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One full session of n words from words[]; bad corrupts the checksum byte.
  task automatic run_load(input int n, input bit bad);
    int         we0;
    int         dn0;
    logic [7:0] cs;
    we0 = we_total;
    dn0 = done_total;
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    if (n > ROM_W) begin
      chk("oversize_err", 32'(err), 32'd1);
      chk("oversize_ready", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("oversize_no_writes", 32'(we_total - we0), 32'd0);
      chk("oversize_err_sticky", 32'(err), 32'd1);
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      send_byte(words[k][15:8]);
      send_byte(words[k][7:0]);
      chk("write_strobe", 32'(imem_we), 32'd1);
      chk("write_addr", 32'(imem_addr), 32'(2 * k));
      chk("write_data", 32'(imem_wdata), 32'(words[k]));
      cs = cs ^ words[k][15:8] ^ words[k][7:0];
    end
    if (bad) cs = cs ^ 8'(1 << $urandom_range(7));
    send_byte(cs);
    if (!bad) begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_no_err", 32'(err), 32'd0);
      chk("finish_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_hold", 32'(cpu_hold), 32'd0);
      chk("done_count", 32'(done_total - dn0), 32'd1);
    end else begin
      chk("bad_csum_err", 32'(err), 32'd1);
      chk("bad_csum_no_done", 32'(done), 32'd0);
      chk("bad_csum_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("bad_csum_done_count", 32'(done_total - dn0), 32'd0);
    end
    chk("write_count", 32'(we_total - we0), 32'(n));
  endtask

  task automatic rand_words();
    for (int i = 0; i < ROM_W; i++) words[i] = 16'($urandom);
  endtask

  initial begin
    int we0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal two-word load, back to back.
    gap_pct = 0;
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_load(2, 1'b0);

    // Same stream with a wrong checksum; error must stay until the next start.
    run_load(2, 1'b1);
    we0 = we_total;
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("error_holds", 32'(err), 32'd1);
    chk("error_ignores_bytes", 32'(we_total - we0), 32'd0);

    // Oversize length, entered from the error state.
    run_load(ROM_W + 1, 1'b0);

    // Zero length: header then checksum 00.
    run_load(0, 1'b0);

    // Bytes offered while idle are ignored.
    we0 = we_total;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      @(negedge clk);
      chk("idle_not_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("idle_no_writes", 32'(we_total - we0), 32'd0);
    chk("idle_still_idle", 32'(busy), 32'd0);

    // Full depth with random valid gaps.
    rand_words();
    gap_pct = 40;
    hold_drops = 0;
    run_load(ROM_W, 1'b0);
    chk("hold_full_depth", 32'(hold_drops), 32'd0);

    // A few random-length loads.
    gap_pct = 25;
    for (int r = 0; r < 4; r++) begin
      rand_words();
      run_load(int'($urandom_range(1, ROM_W)), 1'b0);
    end

    // Reset while the low byte of word 1 is being offered.
    gap_pct = 0;
    rand_words();
    we0 = we_total;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(words[0][15:8]);
    send_byte(words[0][7:0]);
    send_byte(words[1][15:8]);
    in_valid = 1'b1;
    in_byte  = words[1][7:0];
    rst      = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_wdata", 32'(imem_wdata), 32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done_err", 32'({done, err}), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_only_word0", 32'(we_total - we0), 32'd1);

    // Loader still works after the abort.
    rand_words();
    run_load(3, 1'b0);
    chk("hold_all_sessions", 32'(hold_drops), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ROM_WORDS, default 32, instruction-memory depth in 16-bit words.
REQ-002 Parameter ADDR_W, default 16, instruction-memory byte-address width (PC width).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_byte  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte accepted on a cycle where in_valid and in_ready are both 1.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory byte address; always even.
REQ-011 imem_wdata  output  16  instruction word to write.
REQ-012 cpu_hold  output  1  holds the datapath PC and suppresses register/data-memory writes while a session is active.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 Stream format, big-endian: LEN_HI, LEN_LO (N = word count), then N words of 2 bytes each (high byte first), then 1 checksum byte.
REQ-017 Checksum = XOR of every byte after the length field, excluding the checksum byte itself.
REQ-018 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, FINISH, ERROR.
REQ-019 IDLE -> LEN_HI on start=1; start is ignored in every other state except ERROR.
REQ-020 LEN_HI -> LEN_LO -> (DATA_HI if N!=0; CHECK if N==0; ERROR if N>ROM_WORDS); each transition occurs on a byte accept.
REQ-021 DATA_HI -> DATA_LO on accept, latching the high byte.
REQ-022 DATA_LO -> DATA_HI on accept, or -> CHECK when this is word N.
REQ-023 Accepting the low byte of word k (0-based) drives imem_we=1 for exactly the next cycle, with imem_addr = 2*k and imem_wdata = {hi, lo}.
REQ-024 Write latency is 1 cycle after the low-byte accept; writes occur in strictly ascending address order with no gaps.
REQ-025 in_ready=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 in all other states; back-to-back bytes, one per cycle, are sustained.
REQ-026 CHECK, on accept: if the byte equals the running XOR -> FINISH, else -> ERROR.
REQ-027 FINISH lasts one cycle and asserts done=1, then -> IDLE.
REQ-028 In ERROR, err=1 and stays 1 until start is received, which clears err and enters LEN_HI in the same transition.
REQ-029 cpu_hold=1 and busy=1 in every state except IDLE; the last imem_we pulse completes while cpu_hold is still 1.
REQ-030 Word counter width is clog2(ROM_WORDS)+1; N==ROM_WORDS is legal, with the last write at byte address 2*(ROM_WORDS-1).
REQ-031 Bytes offered with in_valid=1 while in IDLE/FINISH/ERROR are not accepted and have no effect.
REQ-032 in_valid=0 mid-word stalls the FSM indefinitely with no timeout; latched state is held.

Reset
REQ-033 rst=1 forces, on the next edge: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 0, busy 0, done 0, err 0, and checksum and counters cleared.
REQ-034 rst asserted mid-session aborts the session; any write pulse pending for that edge is dropped, and already-written words are not restored.
REQ-035 rst has priority over start and byte accepts on the same edge.

Structure
REQ-036 A shared package holds the state enum, ROM_WORDS default, ADDR_W default and checksum width, also used by the datapath-integration wrapper.
REQ-037 Single module with no sub-module; byte assembly, checksum and counter are inline registers.

Verification
REQ-038 Normal load: start, then bytes 00 02 12 34 AB CD, checksum 12^34^AB^CD=40 -> writes (0x0000,0x1234) and (0x0002,0xABCD); done pulse; err=0.
REQ-039 Bad checksum: same stream with checksum 41 -> ERROR, err=1, no done; a following start clears err.
REQ-040 Oversize: length 00 21 (33) -> ERROR directly after LEN_LO; no imem_we pulses.
REQ-041 Zero length: 00 00 then checksum 00 -> done after 3 accepts; no writes.
REQ-042 Full depth: N=32 with in_valid gapped randomly -> 32 writes, last at 0x003E; cpu_hold=1 throughout.
REQ-043 Mid-session reset: rst during DATA_LO of word 1 -> all outputs 0 next cycle; no write to 0x0002.
